sram_wb_bridge: RTL and testbench

SRAM_WB_BRIDGE -- requirements
Module: sram_wb_bridge

---
 rtl/sram_wb_bridge.sv | 83 ++++++++
 tb/tb_sram_wb_bridge.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_wb_bridge.sv
// Wishbone slave that maps a 1 KB window onto a single-port SRAM macro.
// Each request makes at most one SRAM access; reads wait one extra cycle for the macro output.
module sram_wb_bridge #(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  wbs_cyc_i,
    input  logic                  wbs_stb_i,
    input  logic                  wbs_we_i,
    input  logic [3:0]            wbs_sel_i,
    input  logic [31:0]           wbs_adr_i,
    input  logic [31:0]           wbs_dat_i,
    output logic                  wbs_ack_o,
    output logic [31:0]           wbs_dat_o,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [3:0]            sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [31:0]           sram_din0,
    input  logic [31:0]           sram_dout0
);

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        ACK
    } state_t;

    state_t state;
    state_t state_next;
    logic   hit;

    assign hit       = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:10] == BASE_ADDR[31:10]);
    assign wbs_ack_o = (state == ACK);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            wbs_dat_o <= '0;
        end else begin
            state <= state_next;
            // Macro output is valid after its negedge, so capture on leaving RD_WAIT.
            if (state == RD_WAIT && wbs_cyc_i) begin
                wbs_dat_o <= sram_dout0;
            end
        end
    end

    always_comb begin
        state_next  = state;
        sram_csb0   = 1'b1;
        sram_web0   = ~wbs_we_i;
        sram_wmask0 = wbs_sel_i;
        sram_addr0  = wbs_adr_i[ADDR_WIDTH+1:2];
        sram_din0   = wbs_dat_i;
        unique case (state)
            IDLE: begin
                if (hit && !wb_rst_i) begin
                    if (wbs_we_i) begin
                        // An all-zero byte mask is acknowledged without touching the macro.
                        sram_csb0  = (wbs_sel_i == 4'b0000);
                        state_next = ACK;
                    end else begin
                        sram_csb0  = 1'b0;
                        state_next = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                state_next = wbs_cyc_i ? ACK : IDLE;
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sram_wb_bridge.sv
// Bench for sram_wb_bridge: behavioural SRAM macro, transaction-level model and per-cycle compare.
module tb_sram_wb_bridge;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cyc = 1'b0;
    logic          stb = 1'b0;
    logic          we = 1'b0;
    logic [3:0]    sel = 4'h0;
    logic [31:0]   adr = 32'h0;
    logic [31:0]   dat_w = 32'h0;
    logic          ack;
    logic [31:0]   dat_r;
    logic          csb0;
    logic          web0;
    logic [3:0]    wmask0;
    logic [AW-1:0] addr0;
    logic [31:0]   din0;
    logic [31:0]   dout0 = 32'h0;

    sram_wb_bridge #(.BASE_ADDR(BASE), .ADDR_WIDTH(AW)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .wbs_cyc_i  (cyc),
        .wbs_stb_i  (stb),
        .wbs_we_i   (we),
        .wbs_sel_i  (sel),
        .wbs_adr_i  (adr),
        .wbs_dat_i  (dat_w),
        .wbs_ack_o  (ack),
        .wbs_dat_o  (dat_r),
        .sram_csb0  (csb0),
        .sram_web0  (web0),
        .sram_wmask0(wmask0),
        .sram_addr0 (addr0),
        .sram_din0  (din0),
        .sram_dout0 (dout0)
    );

    always #5 clk = ~clk;

    // SRAM macro: latches the request at posedge, writes or reads at the following negedge.
    logic [31:0]   sram_mem [256];
    logic          s_csb = 1'b1;
    logic          s_web = 1'b1;
    logic [3:0]    s_mask = 4'h0;
    logic [AW-1:0] s_addr = '0;
    logic [31:0]   s_din = 32'h0;

    always @(posedge clk) begin
        s_csb  <= csb0;
        s_web  <= web0;
        s_mask <= wmask0;
        s_addr <= addr0;
        s_din  <= din0;
    end

    always @(negedge clk) begin
        if (!s_csb) begin
            if (!s_web) begin
                for (int b = 0; b < 4; b++)
                    if (s_mask[b]) sram_mem[s_addr][8*b +: 8] <= s_din[8*b +: 8];
            end else begin
                dout0 <= sram_mem[s_addr];
            end
        end
    end

    // Transaction-level model: memory image plus edges at which ack/data/issue are due.
    logic [31:0] ref_mem [256];
    int          edge_n = 0;
    logic        rst_at_edge = 1'b0;
    int          ack_edge = -1;
    int          pending_edge = -1;
    logic [31:0] pending_dat = 32'h0;
    logic [31:0] model_dat = 32'h0;
    int          issue_edge = -1;
    logic        issue_real = 1'b0;
    logic        exp_web;
    logic [3:0]  exp_mask;
    logic [7:0]  exp_addr;
    logic [31:0] exp_din;

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %h, expected %h", name, edge_n, act, exp);
        end
    endtask

    always @(posedge clk) begin
        edge_n      <= edge_n + 1;
        rst_at_edge <= rst;
    end

    always @(negedge clk) begin
        logic exp_csb;
        if (edge_n == pending_edge) model_dat = pending_dat;
        if (rst_at_edge) begin
            model_dat    = 32'h0;
            ack_edge     = -1;
            pending_edge = -1;
        end
        if (edge_n > 0) begin
            chk("ack", {31'b0, ack}, {31'b0, edge_n == ack_edge});
            chk("dat_o", dat_r, model_dat);
            exp_csb = !(edge_n == issue_edge && issue_real && !rst);
            chk("csb0", {31'b0, csb0}, {31'b0, exp_csb});
            if (!exp_csb) begin
                chk("web0", {31'b0, web0}, {31'b0, exp_web});
                chk("wmask0", {28'b0, wmask0}, {28'b0, exp_mask});
                chk("addr0", {24'b0, addr0}, {24'b0, exp_addr});
                if (!exp_web) chk("din0", din0, exp_din);
            end
        end
    end

    task automatic idle_bus();
        cyc = 1'b0;
        stb = 1'b0;
        we  = 1'b0;
    endtask

    // One request; abort=1 drops cyc during the read wait cycle. Miss requests are held hold_miss cycles.
    task automatic txn(input logic w, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d, input bit abort, input int hold_miss);
        int  e;
        int  idx;
        bit  hit;
        @(posedge clk); #1;
        e   = edge_n;
        hit = (a[31:10] == BASE[31:10]);
        idx = int'(a[9:2]);
        cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; dat_w = d;
        if (hit) begin
            issue_edge = e;
            issue_real = !(w && s == 4'h0);
            exp_web    = ~w;
            exp_mask   = s;
            exp_addr   = a[9:2];
            exp_din    = d;
            if (w) begin
                ack_edge = e + 1;
                for (int b = 0; b < 4; b++)
                    if (s[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
                repeat (2) @(posedge clk);
            end else if (abort) begin
                @(posedge clk); #1;
                idle_bus();
                repeat (2) @(posedge clk);
            end else begin
                ack_edge     = e + 2;
                pending_edge = e + 2;
                pending_dat  = ref_mem[idx];
                repeat (3) @(posedge clk);
            end
        end else begin
            repeat (hold_miss) @(posedge clk);
        end
        #1;
        idle_bus();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ref_mem[i]  = $urandom;
            sram_mem[i] = ref_mem[i];
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("reset_ack", {31'b0, ack}, 32'h0);
        chk("reset_dat", dat_r, 32'h0);

        txn(1'b1, 32'h3000_0010, 4'hF, 32'hDEAD_BEEF, 1'b0, 0);
        chk("lit_model_word4", ref_mem[4], 32'hDEAD_BEEF);
        txn(1'b0, 32'h3000_0010, 4'h0, 32'h0, 1'b0, 0);
        chk("lit_read_beef", dat_r, 32'hDEAD_BEEF);
        txn(1'b1, 32'h3000_0010, 4'b0010, 32'h0000_5500, 1'b0, 0);
        txn(1'b0, 32'h3000_0010, 4'h1, 32'h0, 1'b0, 0);
        chk("lit_read_55ef", dat_r, 32'hDEAD_55EF);
        txn(1'b1, 32'h3000_0010, 4'h0, 32'hFFFF_FFFF, 1'b0, 0);
        txn(1'b0, 32'h3000_0010, 4'hF, 32'h0, 1'b0, 0);
        chk("lit_sel0_nowrite", dat_r, 32'hDEAD_55EF);
        txn(1'b1, 32'h3000_0400, 4'hF, 32'h1234_5678, 1'b0, 10);
        txn(1'b0, 32'h3000_0020, 4'hF, 32'h0, 1'b1, 0);
        chk("lit_abort_keep", dat_r, 32'hDEAD_55EF);

        // Reset while the read sits in its wait cycle; hit kept present while reset is held.
        begin
            int e;
            @(posedge clk); #1;
            e = edge_n;
            cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h3000_0010;
            issue_edge = e; issue_real = 1'b1;
            exp_web = 1'b1; exp_mask = 4'hF; exp_addr = 8'h04;
            ack_edge = e + 2; pending_edge = e + 2; pending_dat = ref_mem[4];
            @(posedge clk); #1 rst = 1'b1;
            @(posedge clk); #1;
            chk("lit_rst_ack", {31'b0, ack}, 32'h0);
            chk("lit_rst_dat", dat_r, 32'h0);
            chk("lit_rst_csb", {31'b0, csb0}, 32'h1);
            @(posedge clk); #1;
            rst = 1'b0;
            idle_bus();
        end

        for (int n = 0; n < 80; n++) begin
            logic        w;
            logic [31:0] a;
            w = 1'($urandom);
            a = {BASE[31:10], 8'($urandom_range(0, 15)), 2'($urandom)};
            if ($urandom_range(0, 9) == 0) a = a + 32'h400 * $urandom_range(1, 3);
            txn(w, a, 4'($urandom), $urandom, (!w && $urandom_range(0, 7) == 0), 3);
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
